// File: rtl/lcd_text_driver_pkg.sv
// Shared constants, state encodings and helpers for the HD44780 text driver.
// Covers the init command set, the line base addresses and the buffer geometry.
package lcd_text_driver_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;

  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;

  localparam int unsigned LINE_LEN  = 16;
  localparam int unsigned NUM_CHARS = 32;
  localparam int unsigned NUM_INIT  = 4;

  typedef enum logic [2:0] {
    StPwrup,
    StInit,
    StAddr,
    StFetch,
    StChar,
    StIdle
  } top_state_e;

  typedef enum logic [2:0] {
    BwIdle,
    BwSetup,
    BwEpulse,
    BwHold,
    BwWait
  } bus_state_e;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_text_driver_if.sv
// Text-buffer read port plus the HD44780 8-bit parallel bus.
// The master is the driver; the slave side is the buffer and the panel.
interface lcd_text_driver_if;
  logic [4:0] index;
  logic [7:0] char_data;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  modport master (
    output index, lcd_e, lcd_rs, lcd_rw, lcd_data,
    input  char_data
  );

  modport slave (
    input  index, lcd_e, lcd_rs, lcd_rw, lcd_data,
    output char_data
  );
endinterface

// File: rtl/lcd_text_driver_bus_write.sv
// One HD44780 bus write: SETUP, E pulse, HOLD, then the post-write wait.
// RS/DATA are latched on an accepted start and held until the next one.
module lcd_text_driver_bus_write
  import lcd_text_driver_pkg::*;
#(
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_EPW   = 25,
  parameter int unsigned T_HOLD  = 4,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_byte,
  output logic       o_e,
  output logic       o_rs,
  output logic [7:0] o_data,
  output logic       o_done
);

  localparam int unsigned TMax = max2(max2(T_SETUP, T_EPW), max2(max2(T_HOLD, T_CMD), T_CLR));
  localparam int unsigned TW   = $clog2(TMax + 1);

  bus_state_e    r_state;
  logic [TW-1:0] r_timer;
  logic          r_e;
  logic          r_rs;
  logic [7:0]    r_data;
  logic          w_timer_zero;

  assign w_timer_zero = (r_timer == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= BwIdle;
      r_timer <= '0;
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= '0;
    end else begin
      // Every timed phase counts down; the zero cases below reload it.
      if (r_state != BwIdle) r_timer <= r_timer - 1'b1;
      case (r_state)
        BwIdle: begin
          if (i_start) begin
            r_rs    <= i_rs;
            r_data  <= i_byte;
            r_timer <= TW'(T_SETUP - 1);
            r_state <= BwSetup;
          end
        end
        BwSetup: begin
          if (w_timer_zero) begin
            r_e     <= 1'b1;
            r_timer <= TW'(T_EPW - 1);
            r_state <= BwEpulse;
          end
        end
        BwEpulse: begin
          if (w_timer_zero) begin
            r_e     <= 1'b0;
            r_timer <= TW'(T_HOLD - 1);
            r_state <= BwHold;
          end
        end
        BwHold: begin
          if (w_timer_zero) begin
            r_timer <= (!r_rs && r_data == CMD_CLEAR) ? TW'(T_CLR - 1) : TW'(T_CMD - 1);
            r_state <= BwWait;
          end
        end
        BwWait: begin
          if (w_timer_zero) r_state <= BwIdle;
        end
        default: r_state <= BwIdle;
      endcase
    end
  end

  // Asserted during the last wait cycle so the sequencer reacts right after the wait.
  assign o_done = (r_state == BwWait) && w_timer_zero;
  assign o_e    = r_e;
  assign o_rs   = r_rs;
  assign o_data = r_data;

endmodule

// File: rtl/lcd_text_driver.sv
// Sequencer for a 16x2 HD44780 panel: power-up wait, init commands, then a
// continuous refresh of the 32-character buffer, line address before each line.
module lcd_text_driver
  import lcd_text_driver_pkg::*;
#(
  parameter int unsigned T_PWRUP   = 750000,
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_EPW     = 25,
  parameter int unsigned T_HOLD    = 4,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLR     = 82000,
  parameter int unsigned FETCH_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  output logic o_init_done,
  output logic o_frame_done,
  lcd_text_driver_if.master bus
);

  localparam int unsigned CW = $clog2(max2(T_PWRUP, FETCH_LAT) + 1);

  top_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_init_cnt;
  logic [4:0]    r_index;
  logic [7:0]    r_char;
  logic          r_pend;
  logic          r_start;
  logic          r_wr_rs;
  logic [7:0]    r_wr_byte;
  logic          r_init_done;
  logic          r_frame_done;

  logic          w_done;
  logic          w_e;
  logic          w_rs;
  logic [7:0]    w_data;

  lcd_text_driver_bus_write #(
    .T_SETUP (T_SETUP),
    .T_EPW   (T_EPW),
    .T_HOLD  (T_HOLD),
    .T_CMD   (T_CMD),
    .T_CLR   (T_CLR)
  ) u_bus_write (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_start),
    .i_rs    (r_wr_rs),
    .i_byte  (r_wr_byte),
    .o_e     (w_e),
    .o_rs    (w_rs),
    .o_data  (w_data),
    .o_done  (w_done)
  );

  // r_pend marks a write in flight; the first cycle of each write state issues it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StPwrup;
      r_cnt        <= '0;
      r_init_cnt   <= '0;
      r_index      <= '0;
      r_char       <= '0;
      r_pend       <= 1'b0;
      r_start      <= 1'b0;
      r_wr_rs      <= 1'b0;
      r_wr_byte    <= '0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        StPwrup: begin
          if (r_cnt == CW'(T_PWRUP - 1)) begin
            r_cnt   <= '0;
            r_state <= StInit;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StInit: begin
          if (!r_pend) begin
            r_start   <= 1'b1;
            r_pend    <= 1'b1;
            r_wr_rs   <= 1'b0;
            r_wr_byte <= init_cmd(r_init_cnt);
          end else if (w_done) begin
            r_pend <= 1'b0;
            if (r_init_cnt == 2'(NUM_INIT - 1)) begin
              r_init_done <= 1'b1;
              r_state     <= StAddr;
            end else begin
              r_init_cnt <= r_init_cnt + 1'b1;
            end
          end
        end
        StAddr: begin
          if (!r_pend) begin
            r_start   <= 1'b1;
            r_pend    <= 1'b1;
            r_wr_rs   <= 1'b0;
            r_wr_byte <= (r_index == '0) ? LINE1_ADDR : LINE2_ADDR;
          end else if (w_done) begin
            r_pend  <= 1'b0;
            r_cnt   <= '0;
            r_state <= StFetch;
          end
        end
        StFetch: begin
          if (r_cnt == CW'(FETCH_LAT - 1)) begin
            r_char  <= bus.char_data;
            r_cnt   <= '0;
            r_state <= StChar;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StChar: begin
          if (!r_pend) begin
            r_start   <= 1'b1;
            r_pend    <= 1'b1;
            r_wr_rs   <= 1'b1;
            r_wr_byte <= r_char;
          end else if (w_done) begin
            r_pend <= 1'b0;
            if (r_index == 5'(LINE_LEN - 1)) begin
              r_index <= 5'(LINE_LEN);
              r_state <= StAddr;
            end else if (r_index == 5'(NUM_CHARS - 1)) begin
              r_index      <= '0;
              r_frame_done <= 1'b1;
              r_state      <= i_enable ? StAddr : StIdle;
            end else begin
              r_index <= r_index + 1'b1;
              r_cnt   <= '0;
              r_state <= StFetch;
            end
          end
        end
        StIdle: begin
          if (i_enable) r_state <= StAddr;
        end
        default: r_state <= StPwrup;
      endcase
    end
  end

  assign bus.index    = r_index;
  assign bus.lcd_e    = w_e;
  assign bus.lcd_rs   = w_rs;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_data = w_data;
  assign o_init_done  = r_init_done;
  assign o_frame_done = r_frame_done;

endmodule
